// File: rtl/dp_ram_16x4_ed.sv
//------------------------------------------------------------------------------
// Module   : dp_ram_16x4_ed
// Purpose  : 16x4 single-clock dual-port RAM, one write port and one read port.
//            Each word carries an ED sideband bit. The read port is registered.
//            Defining RDW_BYPASS_EN makes a read of the address being written
//            on the same edge return the new data (write-through).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dp_ram_16x4_ed #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int ED_WIDTH   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddress,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic [ED_WIDTH-1:0]   EDI,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] RdAddress,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [ED_WIDTH-1:0]   EDO
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;
  localparam int C_WORD  = DATA_WIDTH + ED_WIDTH;

  logic [C_WORD-1:0] r_mem [C_DEPTH];
  logic [C_WORD-1:0] r_rd_word;
  logic [C_WORD-1:0] w_wr_word;
  logic [C_WORD-1:0] w_rd_next;

  assign w_wr_word = {EDI, Data};

`ifdef RDW_BYPASS_EN
  always_comb begin
    w_rd_next = r_mem[RdAddress];
    if (WrEn && (WrAddress == RdAddress)) begin
      w_rd_next = w_wr_word;
    end
  end
`else
  // Array read sees pre-edge contents, giving read-before-write on collision.
  assign w_rd_next = r_mem[RdAddress];
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WrEn) begin
      r_mem[WrAddress] <= w_wr_word;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rd_word <= '0;
    end else if (RdEn) begin
      r_rd_word <= w_rd_next;
    end
  end

  assign Q   = r_rd_word[DATA_WIDTH-1:0];
  assign EDO = r_rd_word[C_WORD-1:DATA_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_16x4_ed.sv
//------------------------------------------------------------------------------
// Module   : tb_dp_ram_16x4_ed
// Purpose  : Directed plus randomized checks of dp_ram_16x4_ed against an
//            array-based reference model (honours RDW_BYPASS_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dp_ram_16x4_ed;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       WrEn = 1'b0;
  logic [3:0] WrAddress = '0;
  logic [3:0] Data = '0;
  logic [0:0] EDI = '0;
  logic       RdEn = 1'b0;
  logic [3:0] RdAddress = '0;
  logic [3:0] Q;
  logic [0:0] EDO;

  int checks = 0;
  int failures = 0;

  logic [4:0] model [16];
  logic [4:0] exp_out;

  dp_ram_16x4_ed dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .WrEn      (WrEn),
    .WrAddress (WrAddress),
    .Data      (Data),
    .EDI       (EDI),
    .RdEn      (RdEn),
    .RdAddress (RdAddress),
    .Q         (Q),
    .EDO       (EDO)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {EDO, Q};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={EDO,Q}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_out = '0;
  endtask

  // One clock: drive inputs, predict, advance to 1ns past the edge.
  task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] d,
                      input logic e, input logic re, input logic [3:0] ra);
    WrEn = we; WrAddress = wa; Data = d; EDI = e; RdEn = re; RdAddress = ra;
    if (re) begin
`ifdef RDW_BYPASS_EN
      exp_out = (we && wa == ra) ? {e, d} : model[ra];
`else
      exp_out = model[ra];
`endif
    end
    if (we) model[wa] = {e, d};
    @(posedge Clock);
    #1;
  endtask

  initial begin
    model_clear();
    #2;
    chk("reset_state", 5'h00);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Write-enable gating straight after reset
    step(1'b0, 4'd1, 4'hE, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd1);
    chk("wren_gating", exp_out);
    chk("wren_gating_zero", 5'h00);

    // Get Q=A, then assert reset mid-cycle
    step(1'b1, 4'd0, 4'hA, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd0);
    chk("pre_reset_q", 5'h1A);
    #4;
    Reset = 1'b1;
    #1;
    chk("async_reset_q", 5'h00);
    model_clear();
    @(posedge Clock); #1;
    Reset = 1'b0;
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd7);
    chk("post_reset_rd7", 5'h00);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd0);
    chk("post_reset_rd0", 5'h00);

    // Fill and read back every word
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 4'(a), 4'(a) ^ 4'h5, a[0], 1'b0, 4'd0);
    end
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'(a));
      chk($sformatf("fill_rd%0d", a), {a[0], 4'(a) ^ 4'h5});
    end

    // Read hold
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd3);
    chk("hold_rd3", 5'h16);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'd9);
    chk("hold_rden0", 5'h16);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 4'd9);
    chk("hold_rden0_2", 5'h16);

    // Same-address collision
    step(1'b1, 4'd2, 4'h1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 4'd2, 4'hF, 1'b1, 1'b1, 4'd2);
`ifdef RDW_BYPASS_EN
    chk("collision_bypass", 5'h1F);
`else
    chk("collision_old", 5'h01);
`endif
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd2);
    chk("collision_next", 5'h1F);

    // Different-address concurrency
    step(1'b1, 4'd4, 4'h3, 1'b0, 1'b0, 4'd0);
    step(1'b1, 4'd5, 4'hC, 1'b0, 1'b1, 4'd4);
    chk("diff_addr_rd4", 5'h03);
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd5);
    chk("diff_addr_rd5", 5'h0C);

    // In-flight write discarded when reset asserts before the edge
    WrEn = 1'b1; WrAddress = 4'd8; Data = 4'h9; EDI = 1'b1; RdEn = 1'b0;
    #3;
    Reset = 1'b1;
    model_clear();
    @(posedge Clock); #1;
    Reset = 1'b0;
    step(1'b0, 4'd0, 4'h0, 1'b0, 1'b1, 4'd8);
    chk("inflight_write_dropped", 5'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic       we, re, e;
      logic [3:0] wa, ra, d;
      we = 1'($urandom);
      re = 1'($urandom);
      e  = 1'($urandom);
      wa = 4'($urandom);
      d  = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      step(we, wa, d, e, re, ra);
      chk($sformatf("rand%0d", n), exp_out);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
